// File: rtl/cordic_req_sched_if.sv
// cordic_req_sched_if: requester-side request/response bundle for the CORDIC scheduler
interface cordic_req_sched_if #(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_angle;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_valid;
  logic [N_REQ-1:0] rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_cos;
  logic [DATA_WIDTH-1:0] rsp_sin;
  logic [ID_W-1:0] rsp_id;
  logic rsp_err;
  modport master (
    output req_valid, req_angle, rsp_ready,
    input req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_id, rsp_err
  );
  modport slave (
    input req_valid, req_angle, rsp_ready,
    output req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_id, rsp_err
  );
endinterface

// File: rtl/cordic_req_sched.sv
// cordic_req_sched: round-robin sharing of one CORDIC engine among N_REQ requesters
module cordic_req_sched #(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cordic_req_sched_if.slave     bus,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_angle,
  input  logic [DATA_WIDTH-1:0] core_x,
  input  logic [DATA_WIDTH-1:0] core_y,
  input  logic                  core_done,
  output logic                  busy,
  output logic [7:0]            timeout_cnt
);
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, id, win;
  logic [ID_W:0] jj;
  logic found, done_prev, done_edge, wd_hit, ack;
  logic [CW-1:0] wd;
  logic [DATA_WIDTH-1:0] angle, cos_r, sin_r;
  logic err_r;
  logic [N_REQ-1:0] rsp_valid_r, id_onehot;
  logic [7:0] tcnt;
  // only a fresh rising edge of done counts, so a done left high by a prior op is ignored
  assign done_edge = core_done & ~done_prev;
  assign wd_hit = wd == CW'(TIMEOUT_CYC - 1);
  assign ack = bus.rsp_ready[id];
  assign id_onehot = N_REQ'(1) << id;
  assign core_angle = angle;
  assign timeout_cnt = tcnt;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_cos = cos_r;
  assign bus.rsp_sin = sin_r;
  assign bus.rsp_id = id;
  assign bus.rsp_err = err_r;
  // round-robin scan starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    win = '0;
    jj = '0;
    for (int k = 0; k < N_REQ; k++) begin
      jj = {1'b0, rr_ptr} + (ID_W+1)'(k);
      jj = (jj >= (ID_W+1)'(N_REQ)) ? jj - (ID_W+1)'(N_REQ) : jj;
      if (!found && bus.req_valid[jj[ID_W-1:0]]) begin
        found = 1'b1;
        win = jj[ID_W-1:0];
      end
    end
  end
  // next-state and control outputs; grants are suppressed while reset is held
  always_comb begin
    state_n = state;
    bus.req_ready = '0;
    core_start = state == S_LAUNCH;
    busy = state != S_IDLE;
    case (state)
      S_IDLE: begin
        state_n = found ? S_LAUNCH : S_IDLE;
        bus.req_ready = (found && rst_n) ? N_REQ'(1) << win : '0;
      end
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: state_n = (done_edge || wd_hit) ? S_RESP : S_WAIT;
      S_RESP: state_n = ack ? S_IDLE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  // datapath: latch request, run watchdog, capture result, advance round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      id <= '0;
      angle <= '0;
      done_prev <= 1'b0;
      wd <= '0;
      cos_r <= '0;
      sin_r <= '0;
      err_r <= 1'b0;
      rsp_valid_r <= '0;
      tcnt <= '0;
    end else begin
      done_prev <= core_done;
      case (state)
        S_IDLE: if (found) begin
          angle <= bus.req_angle[win*DATA_WIDTH +: DATA_WIDTH];
          id <= win;
        end
        S_LAUNCH: wd <= '0;
        S_WAIT: if (done_edge) begin
          cos_r <= core_x;
          sin_r <= core_y;
          err_r <= 1'b0;
          rsp_valid_r <= id_onehot;
        end else if (wd_hit) begin
          cos_r <= '0;
          sin_r <= '0;
          err_r <= 1'b1;
          rsp_valid_r <= id_onehot;
          tcnt <= (&tcnt) ? tcnt : tcnt + 8'd1;
        end else wd <= wd + 1'b1;
        S_RESP: if (ack) begin
          rsp_valid_r <= '0;
          rr_ptr <= (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cordic_req_sched.sv
// tb_cordic_req_sched: directed self-checking bench for the CORDIC request scheduler
module tb_cordic_req_sched;
  logic clk = 0;
  logic rst_n;
  logic core_start, core_done, busy;
  logic [15:0] core_angle, core_x, core_y;
  logic [7:0] timeout_cnt;
  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int n, s0;
  logic [3:0] grants[$];
  cordic_req_sched_if #(.N_REQ(4), .DATA_WIDTH(16)) bus ();
  cordic_req_sched #(.N_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .core_start(core_start),
    .core_angle(core_angle), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .busy(busy), .timeout_cnt(timeout_cnt)
  );
  always #5 clk = ~clk;
  // count engine start pulses away from the active edge
  always @(negedge clk) if (core_start) starts++;
  // log accepted grants in order
  always @(posedge clk) if (rst_n && bus.req_ready != 0) grants.push_back(bus.req_ready);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_start(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = core_start;
    end
    check({tag, "_start"}, 32'(ok), 1);
  endtask
  task automatic pulse_done(input logic [15:0] x, input logic [15:0] y);
    core_x = x;
    core_y = y;
    core_done = 1;
    @(negedge clk);
    core_done = 0;
  endtask
  task automatic ack(input logic [3:0] m, input string tag);
    bus.rsp_ready = m;
    @(negedge clk);
    bus.rsp_ready = 0;
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_rsp_clr"}, 32'(bus.rsp_valid), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0;
    bus.req_valid = 0;
    bus.req_angle = 0;
    bus.rsp_ready = 0;
    core_x = 0;
    core_y = 0;
    core_done = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_core_start", 32'(core_start), 0);
    check("rst_core_angle", 32'(core_angle), 0);
    check("rst_timeout_cnt", 32'(timeout_cnt), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    rst_n = 1;
    @(negedge clk);
    bus.req_angle[2*16 +: 16] = 16'h1922;
    bus.req_valid = 4'b0100;
    #1 check("t1_req_ready", 32'(bus.req_ready), 4'b0100);
    wait_start("t1");
    bus.req_valid = 0;
    check("t1_core_angle", 32'(core_angle), 16'h1922);
    check("t1_busy", 32'(busy), 1);
    repeat (17) @(negedge clk);
    check("t1_no_rsp_yet", 32'(bus.rsp_valid), 0);
    pulse_done(16'h2D41, 16'h2D41);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 4'b0100);
    check("t1_cos", 32'(bus.rsp_cos), 16'h2D41);
    check("t1_sin", 32'(bus.rsp_sin), 16'h2D41);
    check("t1_err", 32'(bus.rsp_err), 0);
    check("t1_id", 32'(bus.rsp_id), 2);
    check("t1_one_start", 32'(starts), 1);
    ack(4'b0100, "t1");
    bus.req_angle[1*16 +: 16] = 16'h0ABC;
    bus.req_valid = 4'b0010;
    wait_start("t3");
    bus.req_valid = 0;
    n = 0;
    for (int i = 1; i <= 100 && bus.rsp_valid == 0; i++) begin
      @(negedge clk);
      n = i;
    end
    check("t3_wait_cycles", 32'(n), 65);
    check("t3_rsp_valid", 32'(bus.rsp_valid), 4'b0010);
    check("t3_err", 32'(bus.rsp_err), 1);
    check("t3_cos", 32'(bus.rsp_cos), 0);
    check("t3_sin", 32'(bus.rsp_sin), 0);
    check("t3_timeout_cnt", 32'(timeout_cnt), 1);
    ack(4'b0010, "t3");
    bus.req_valid = 4'b0010;
    wait_start("t3b");
    bus.req_valid = 0;
    repeat (5) @(negedge clk);
    pulse_done(16'h1234, 16'h5678);
    check("t3b_rsp_valid", 32'(bus.rsp_valid), 4'b0010);
    check("t3b_err", 32'(bus.rsp_err), 0);
    check("t3b_cos", 32'(bus.rsp_cos), 16'h1234);
    check("t3b_sin", 32'(bus.rsp_sin), 16'h5678);
    check("t3b_timeout_cnt", 32'(timeout_cnt), 1);
    ack(4'b0010, "t3b");
    core_x = 16'hDEAD;
    core_y = 16'hDEAD;
    core_done = 1;
    bus.req_angle[3*16 +: 16] = 16'h3000;
    bus.req_valid = 4'b1000;
    wait_start("t4");
    bus.req_valid = 0;
    repeat (2) @(negedge clk);
    core_done = 0;
    repeat (16) @(negedge clk);
    check("t4_stale_ignored", 32'(bus.rsp_valid), 0);
    pulse_done(16'h0F0F, 16'hF0F0);
    check("t4_rsp_valid", 32'(bus.rsp_valid), 4'b1000);
    check("t4_cos", 32'(bus.rsp_cos), 16'h0F0F);
    check("t4_sin", 32'(bus.rsp_sin), 16'hF0F0);
    ack(4'b1000, "t4");
    bus.req_angle[0 +: 16] = 16'h0555;
    bus.req_valid = 4'b0001;
    wait_start("t5");
    bus.req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    pulse_done(16'h1111, 16'h2222);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 4'b0001);
    s0 = starts;
    bus.rsp_ready = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(bus.rsp_valid), 4'b0001);
      check("t5_hold_cos", 32'(bus.rsp_cos), 16'h1111);
      check("t5_no_grant", 32'(bus.req_ready), 0);
    end
    check("t5_no_start", 32'(starts), 32'(s0));
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    bus.rsp_ready = 0;
    check("t5_next_grant", 32'(bus.req_ready), 4'b0010);
    wait_start("t5b");
    bus.req_valid = 0;
    repeat (2) @(negedge clk);
    pulse_done(16'h0101, 16'h0202);
    check("t5b_id", 32'(bus.rsp_id), 1);
    check("t5b_cos", 32'(bus.rsp_cos), 16'h0101);
    ack(4'b0010, "t5b");
    bus.req_angle[2*16 +: 16] = 16'h2222;
    bus.req_valid = 4'b0100;
    wait_start("t6");
    bus.req_valid = 0;
    repeat (5) @(negedge clk);
    s0 = starts;
    rst_n = 0;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    check("t6_core_start", 32'(core_start), 0);
    check("t6_core_angle", 32'(core_angle), 0);
    check("t6_timeout_cnt", 32'(timeout_cnt), 0);
    bus.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) bus.req_angle[i*16 +: 16] = 16'(16'h0100 * (i + 1));
    repeat (3) @(negedge clk);
    check("t6_rst_req_ready", 32'(bus.req_ready), 0);
    check("t6_rst_no_rsp", 32'(bus.rsp_valid), 0);
    check("t6_rst_no_start", 32'(starts), 32'(s0));
    bus.rsp_ready = 4'hF;
    grants.delete();
    rst_n = 1;
    #1 check("t6_first_grant", 32'(bus.req_ready), 4'b0001);
    for (int op = 0; op < 5; op++) begin
      wait_start("t2");
      check("t2_angle", 32'(core_angle), 32'(16'h0100 * (op % 4 + 1)));
      repeat (2) @(negedge clk);
      pulse_done(16'(op + 16'h40), 16'(op + 16'h80));
      check("t2_rsp_valid", 32'(bus.rsp_valid), 32'(1) << (op % 4));
      check("t2_rsp_id", 32'(bus.rsp_id), 32'(op % 4));
      check("t2_cos", 32'(bus.rsp_cos), 32'(op + 16'h40));
      check("t2_sin", 32'(bus.rsp_sin), 32'(op + 16'h80));
      if (op == 4) bus.req_valid = 0;
    end
    repeat (2) @(negedge clk);
    bus.rsp_ready = 0;
    check("t2_grant_count", 32'(grants.size()), 5);
    for (int k = 0; k < 5 && k < grants.size(); k++)
      check("t2_grant_order", 32'(grants[k]), 32'(1) << (k % 4));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
